// File: rtl/shifter_pkg.sv
// ============================================================================
// Module : shifter_pkg
// Brief  : Shared mode encodings and types for the pipelined barrel shifter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t MODE_SRL = 2'b00;
    localparam shift_mode_t MODE_SLL = 2'b01;
    localparam shift_mode_t MODE_SRA = 2'b10;
    localparam shift_mode_t MODE_ROR = 2'b11;

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module : shift_stage
// Brief  : One pipeline stage: conditional shift by 2^STAGE, then a register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2W = 3,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  shift_mode_t      in_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LOG2W-1:0] out_amt,
    output shift_mode_t      out_mode
);

    localparam int SHIFT = 1 << STAGE;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [LOG2W-1:0] r_amt;
    shift_mode_t      r_mode;

    // SRA keeps the MSB at every stage, so the original sign propagates
    // through later stages without being carried separately.
    always_comb begin
        w_shifted = in_data;
        unique case (in_mode)
            MODE_SRL: w_shifted = in_data >> SHIFT;
            MODE_SLL: w_shifted = in_data << SHIFT;
            MODE_SRA: w_shifted = WIDTH'($signed(in_data) >>> SHIFT);
            MODE_ROR: w_shifted = (in_data >> SHIFT) | (in_data << (WIDTH - SHIFT));
            default:  w_shifted = in_data;
        endcase
    end

    // The amount is consumed LSB-first; each stage only looks at bit 0.
    assign w_next = in_amt[0] ? w_shifted : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= MODE_SRL;
        end else if (advance) begin
            r_valid <= in_valid;
            r_data  <= w_next;
            r_amt   <= in_amt >> 1;
            r_mode  <= in_mode;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_amt   = r_amt;
    assign out_mode  = r_mode;

endmodule : shift_stage

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
// Module : barrel_shifter_pipe
// Brief  : LOG2W-deep pipelined barrel shifter (SRL/SLL/SRA/ROR), valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    generate
        if (LOG2W != $clog2(WIDTH)) begin : g_bad_param
            $error("LOG2W must equal log2(WIDTH)");
        end
    endgenerate

    logic [LOG2W:0]   w_valid;
    logic [WIDTH-1:0] w_data [0:LOG2W];
    logic [LOG2W-1:0] w_amt  [0:LOG2W];
    shift_mode_t      w_mode [0:LOG2W];
    logic             w_stall;
    logic             w_unused;

    // All stages move in lockstep; the only back-pressure source is the output.
    assign w_stall  = w_valid[LOG2W] & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_valid[0] = in_valid & in_ready;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;
    assign w_mode[0]  = in_mode;

    generate
        for (genvar k = 0; k < LOG2W; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .LOG2W (LOG2W),
                .STAGE (k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .advance   (in_ready),
                .in_valid  (w_valid[k]),
                .in_data   (w_data[k]),
                .in_amt    (w_amt[k]),
                .in_mode   (w_mode[k]),
                .out_valid (w_valid[k+1]),
                .out_data  (w_data[k+1]),
                .out_amt   (w_amt[k+1]),
                .out_mode  (w_mode[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[LOG2W];
    assign out_data  = w_valid[LOG2W] ? w_data[LOG2W] : '0;
    assign out_zero  = w_valid[LOG2W] & (w_data[LOG2W] == '0);

    assign w_unused = ^{w_amt[LOG2W], w_mode[LOG2W]};

endmodule : barrel_shifter_pipe

`default_nettype wire
